// File: rtl/multi_lane_dispatcher.sv
// -----------------------------------------------------------------------------
// multi_lane_dispatcher
//   Buffers activation groups (GROUP_SIZE elements + a skip mask) and weights
//   in two small FIFOs. Each non-skipped element of the head group goes to one
//   of NUM_LANES output lanes, lowest index first. The group is emitted over as
//   many beats as it needs. The current weight is attached to every beat.
//   A weight is reused for num_reads_per_iter groups. The whole job covers
//   num_iters weights and then raises done_out.
//
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   configure            load num_iters / num_reads_per_iter, start a job
//   act_data_in/valid    activation group write; skip mask in the top bits
//   act_avail_out        activation FIFO can accept a write
//   weight_data_in/valid weight write
//   weight_avail_out     weight FIFO can accept a write
//   data_out             NUM_LANES x {index, activation}
//   lane_valid_out       per-lane valid
//   weight_out           weight for the current beat
//   last_out             final beat of the current group
//   valid_out            a beat is performed this cycle
//   avail_in             downstream can accept a beat
//   done_out             configured work finished
// -----------------------------------------------------------------------------

// Small FIFO with a combinational head. "avail" is deasserted one entry early,
// so the effective capacity is DEPTH-1. A write is accepted only when avail
// is high.
module dispatcher_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             avail
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             full, almost_full, wr_en, pop;

  assign full        = (count_reg == (PTR_W+1)'(DEPTH));
  assign almost_full = (count_reg == (PTR_W+1)'(DEPTH - 1));
  assign avail       = ~full & ~almost_full;
  assign empty       = (count_reg == '0);
  assign wr_en       = wr_valid & avail;
  assign pop         = rd_en & ~empty;
  assign rd_data     = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

module multi_lane_dispatcher #(
  parameter int GROUP_SIZE             = 8,
  parameter int NUM_LANES              = 2,
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int FIFO_DEPTH             = 4,
  localparam int IDX_WIDTH   = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1,
  localparam int INPUT_WIDTH = GROUP_SIZE*DATA_WIDTH + GROUP_SIZE,
  localparam int LANE_WIDTH  = DATA_WIDTH + IDX_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [INPUT_WIDTH-1:0]            act_data_in,
  input  logic                              act_valid_in,
  output logic                              act_avail_out,
  input  logic [DATA_WIDTH-1:0]             weight_data_in,
  input  logic                              weight_valid_in,
  output logic                              weight_avail_out,
  output logic [NUM_LANES*LANE_WIDTH-1:0]   data_out,
  output logic [NUM_LANES-1:0]              lane_valid_out,
  output logic [DATA_WIDTH-1:0]             weight_out,
  output logic                              last_out,
  output logic                              valid_out,
  input  logic                              avail_in,
  output logic                              done_out
);
  logic [INPUT_WIDTH-1:0]            act_head;
  logic [DATA_WIDTH-1:0]             weight_head;
  logic                              act_empty, weight_empty;
  logic                              act_pop, weight_pop;

  logic                              enabled_reg, done_reg, mid_group_reg;
  logic [GROUP_SIZE-1:0]             pending_reg;
  logic [LOG_MAX_ITERS-1:0]          iters_reg;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_reg, reads_cfg_reg;

  logic                              fire, group_last, reads_at_one;
  logic [GROUP_SIZE-1:0]             skip_mask, candidates, remaining;
  logic [DATA_WIDTH-1:0]             elems [GROUP_SIZE];
  logic                              found;

  dispatcher_fifo #(.WIDTH(INPUT_WIDTH), .DEPTH(FIFO_DEPTH)) act_fifo (
    .clk(clk), .rst(rst), .wr_valid(act_valid_in), .wr_data(act_data_in),
    .rd_en(act_pop), .rd_data(act_head), .empty(act_empty), .avail(act_avail_out)
  );

  dispatcher_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) weight_fifo (
    .clk(clk), .rst(rst), .wr_valid(weight_valid_in), .wr_data(weight_data_in),
    .rd_en(weight_pop), .rd_data(weight_head), .empty(weight_empty), .avail(weight_avail_out)
  );

  genvar gi;
  generate
    for (gi = 0; gi < GROUP_SIZE; gi++) begin : g_elem
      assign elems[gi] = act_head[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign skip_mask = act_head[INPUT_WIDTH-1 -: GROUP_SIZE];
  // The first beat of a group draws from the skip mask. Later beats draw from
  // what the previous beats left behind.
  assign candidates = mid_group_reg ? pending_reg : ~skip_mask;

  // A configure cycle never beats, even if a previous job is still enabled.
  assign fire = enabled_reg & ~configure & avail_in & ~act_empty & ~weight_empty;

  // Peel the lowest-indexed candidates off one lane at a time.
  always_comb begin
    remaining      = candidates;
    data_out       = '0;
    lane_valid_out = '0;
    found          = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      found = 1'b0;
      for (int i = 0; i < GROUP_SIZE; i++) begin
        if (!found && remaining[i]) begin
          found             = 1'b1;
          remaining[i]      = 1'b0;
          lane_valid_out[k] = 1'b1;
          data_out[k*LANE_WIDTH +: LANE_WIDTH] = {IDX_WIDTH'(i), elems[i]};
        end
      end
    end
  end

  assign group_last   = (remaining == '0);
  assign reads_at_one = (reads_reg == LOG_MAX_READS_PER_ITER'(1));
  assign act_pop      = fire & group_last;
  assign weight_pop   = act_pop & reads_at_one;

  assign weight_out = weight_head;
  assign last_out   = group_last;
  assign valid_out  = fire;
  assign done_out   = done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enabled_reg   <= 1'b0;
      done_reg      <= 1'b0;
      mid_group_reg <= 1'b0;
      pending_reg   <= '0;
      iters_reg     <= '0;
      reads_reg     <= '0;
      reads_cfg_reg <= '0;
    end else if (configure) begin
      iters_reg     <= num_iters;
      reads_reg     <= num_reads_per_iter;
      reads_cfg_reg <= num_reads_per_iter;
      pending_reg   <= '0;
      mid_group_reg <= 1'b0;
      // A zero-length job completes immediately.
      if (num_iters == '0 || num_reads_per_iter == '0) begin
        enabled_reg <= 1'b0;
        done_reg    <= 1'b1;
      end else begin
        enabled_reg <= 1'b1;
        done_reg    <= 1'b0;
      end
    end else if (fire) begin
      if (group_last) begin
        mid_group_reg <= 1'b0;
        pending_reg   <= '0;
        if (reads_at_one) begin
          reads_reg <= reads_cfg_reg;
          iters_reg <= iters_reg - 1'b1;
          if (iters_reg == LOG_MAX_ITERS'(1)) begin
            enabled_reg <= 1'b0;
            done_reg    <= 1'b1;
          end
        end else begin
          reads_reg <= reads_reg - 1'b1;
        end
      end else begin
        mid_group_reg <= 1'b1;
        pending_reg   <= remaining;
      end
    end
  end
endmodule

// File: doc/multi_lane_dispatcher.md
MULTI_LANE_DISPATCHER -- requirements
Module: multi_lane_dispatcher

Interface
REQ-001 SHALL have parameter GROUP_SIZE, default 8: number of activations per input group.
REQ-002 SHALL have parameter NUM_LANES, default 2: maximum activations emitted per output beat; 1 <= NUM_LANES <= GROUP_SIZE.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: activation and weight width.
REQ-004 SHALL have parameter LOG_MAX_ITERS, default 16: width of the iteration counter.
REQ-005 SHALL have parameter LOG_MAX_READS_PER_ITER, default 16: width of the reads-per-iteration counter.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: slots in each input FIFO (power of 2).
REQ-007 SHALL derive localparams IDX_WIDTH = clog2(GROUP_SIZE), min 1; INPUT_WIDTH = GROUP_SIZE*DATA_WIDTH + GROUP_SIZE; LANE_WIDTH = DATA_WIDTH + IDX_WIDTH.
REQ-008 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- configure  in  1  load configuration
- num_iters  in  LOG_MAX_ITERS  iteration count
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  groups per weight
- act_data_in  in  INPUT_WIDTH  element i at [i*DATA_WIDTH +: DATA_WIDTH]; skip mask in the top GROUP_SIZE bits (bit i = 1 means skip element i)
- act_valid_in  in  1  write activation group
- act_avail_out  out  1  activation FIFO can accept
- weight_data_in  in  DATA_WIDTH  weight
- weight_valid_in  in  1  write weight
- weight_avail_out  out  1  weight FIFO can accept
- data_out  out  NUM_LANES*LANE_WIDTH  lane k = {index, activation} at [k*LANE_WIDTH +: LANE_WIDTH]
- lane_valid_out  out  NUM_LANES  per-lane valid
- weight_out  out  DATA_WIDTH  weight for the current beat
- last_out  out  1  final beat of the group
- valid_out  out  1  beat performed this cycle
- avail_in  in  1  downstream can accept
- done_out  out  1  configured work finished

Function
REQ-009 SHALL buffer activations and weights in separate FIFO_DEPTH FIFOs; a write with avail_out low is dropped; avail_out = ~full & ~almost_full.
REQ-010 SHALL perform a beat when enabled & avail_in & act FIFO non-empty & weight FIFO non-empty; valid_out equals that condition, combinationally.
REQ-011 SHALL hold state and outputs when no beat is performed, and SHALL NOT change state while valid_out is low.
REQ-012 SHALL keep a pending register of GROUP_SIZE bits. On the first beat of a group, the candidate set is ~mask. On later beats, the candidate set is pending.
REQ-013 SHALL assign, in each beat, the lowest-indexed remaining candidates to lanes 0.. in ascending index order, up to NUM_LANES. Unused lanes have lane_valid 0 and data zero.
REQ-014 SHALL clear the sent bits from pending and assert last_out when no candidates remain. It SHALL pop the activation FIFO on the last_out beat.
REQ-015 SHALL emit each group in max(1, ceil(popcount(~mask)/NUM_LANES)) beats.
REQ-016 SHALL consume an all-skip group (mask all ones) in one beat with lane_valid_out = 0 and last_out = 1.
REQ-017 SHALL drive weight_out from the weight FIFO head on every beat.
REQ-018 SHALL decrement the reads counter on each group pop. When a pop occurs with the reads counter at 1, it SHALL:
- pop the weight FIFO;
- reload the reads counter from the configured copy;
- decrement the iteration counter.
REQ-019 SHALL, on a group pop with both counters at 1, clear enabled and set done_out on the next edge.
REQ-020 SHALL, on configure, load both counters and the copy, clear pending and done_out, and set enabled. No beat is performed that cycle; FIFO contents are kept.
REQ-021 SHALL, on configure with num_iters = 0 or num_reads_per_iter = 0, leave enabled low and set done_out on the next edge.
REQ-022 SHALL keep done_out high until the next configure or reset.

Reset
REQ-023 SHALL, while rst = 0, empty both FIFOs, clear pending and counters, and drive enabled = 0, done_out = 0, valid_out = 0, act_avail_out = 1, weight_avail_out = 1.
REQ-024 SHALL discard any partially sent group when reset is asserted mid-group; no beat of that group follows.

Verification (GROUP_SIZE=4, NUM_LANES=2, DATA_WIDTH=8)
REQ-025 SHALL cover: configure iters=1 reads=1; weight 7; group [1,2,3,4] mask 0000 -> beat1 lanes {0,1},{1,2} w=7 last=0; beat2 {2,3},{3,4} last=1; done_out=1 next cycle.
REQ-026 SHALL cover: group mask 1011, element2 = 9 -> one beat, lane_valid=01, lane0 = {2,9}, last=1.
REQ-027 SHALL cover: group mask 1111 -> one beat, lane_valid=00, last=1, activation FIFO popped.
REQ-028 SHALL cover: avail_in low for 3 cycles between beat1 and beat2 of a mask-0000 group -> valid_out=0 and no state change for those cycles; beat2 unchanged after.
REQ-029 SHALL cover: iters=2, reads=2, weights 5,6, four mask-0111 groups -> groups 1-2 carry w=5, groups 3-4 carry w=6; done_out after group 4.
REQ-030 SHALL cover: rst low after beat1 of a mask-0000 group, then reconfigure with a new group -> first beat comes from the new group; both FIFOs empty after reset.
